tdm_rx_frame_buffer: RTL and testbench

TDM_RX_FRAME_BUFFER -- requirements
Module: tdm_rx_frame_buffer

---
 rtl/tdm_rx_frame_buffer.sv | 164 ++++++++++++++++
 tb/tb_tdm_rx_frame_buffer.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tdm_rx_frame_buffer.sv
// TDM receive frame buffer: deserialises an asynchronous TDM stream into
// per-channel samples, writes them into one of two io_mem banks, and flags
// completed frames and framing errors.
module tdm_rx_frame_buffer #(
   parameter int IO_WIDTH      = 24,
   parameter int SLOT_WIDTH    = 32,
   parameter int NUM_CHANNELS  = 8,
   parameter int CH_ADDR_WIDTH = $clog2(NUM_CHANNELS)
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     tdm_bclk,
   input  logic                     tdm_fs,
   input  logic                     tdm_sdata,
   output logic                     io_wr_en,
   output logic [CH_ADDR_WIDTH:0]   io_wr_addr,
   output logic [IO_WIDTH-1:0]      io_wr_data,
   output logic                     frame_done,
   output logic                     frame_bank,
   output logic                     frame_err,
   output logic [7:0]               err_count
);

   localparam int BIT_W = (SLOT_WIDTH > 1) ? $clog2(SLOT_WIDTH) : 1;

   typedef enum logic [1:0] {IDLE, RUN, WAIT_FS} state_t;

   // synchronizer stages; bclk_d3_q is the previous synchronized bclk for edge detect
   logic bclk_s1_q, bclk_s2_q, bclk_d3_q;
   logic fs_s1_q, fs_s2_q;
   logic sdata_s1_q, sdata_s2_q;

   state_t                   state_q;
   logic                     bank_q;
   logic [BIT_W-1:0]         bit_cnt_q;
   logic [CH_ADDR_WIDTH-1:0] slot_cnt_q;
   logic [IO_WIDTH-1:0]      shift_q;
   logic                     done_pend_q;
   logic                     io_wr_en_q;
   logic [CH_ADDR_WIDTH:0]   io_wr_addr_q;
   logic [IO_WIDTH-1:0]      io_wr_data_q;
   logic                     frame_done_q;
   logic                     frame_bank_q;
   logic                     frame_err_q;
   logic [7:0]               err_count_q;

   logic                     bclk_rise;
   logic                     capture;
   logic                     short_err;
   logic [BIT_W-1:0]         cap_bit;
   logic [CH_ADDR_WIDTH-1:0] cap_slot;
   logic [IO_WIDTH-1:0]      shift_d;
   logic                     in_word;
   logic                     wr_hit;
   logic                     last_bit;
   logic                     last_slot;

   // two-flop synchronizers for the serial inputs, plus one extra bclk stage for edge detection
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bclk_s1_q  <= 1'b0;
         bclk_s2_q  <= 1'b0;
         bclk_d3_q  <= 1'b0;
         fs_s1_q    <= 1'b0;
         fs_s2_q    <= 1'b0;
         sdata_s1_q <= 1'b0;
         sdata_s2_q <= 1'b0;
      end else begin
         bclk_s1_q  <= tdm_bclk;
         bclk_s2_q  <= bclk_s1_q;
         bclk_d3_q  <= bclk_s2_q;
         fs_s1_q    <= tdm_fs;
         fs_s2_q    <= fs_s1_q;
         sdata_s1_q <= tdm_sdata;
         sdata_s2_q <= sdata_s1_q;
      end
   end

   // decode the position of the bit being captured; an fs bit always restarts at slot 0 bit 0
   always_comb begin
      bclk_rise = bclk_s2_q & ~bclk_d3_q;
      capture   = bclk_rise & ((state_q == RUN) | fs_s2_q);
      short_err = bclk_rise & (state_q == RUN) & fs_s2_q;
      cap_bit   = fs_s2_q ? '0 : bit_cnt_q;
      cap_slot  = fs_s2_q ? '0 : slot_cnt_q;
      shift_d   = ((fs_s2_q ? {IO_WIDTH{1'b0}} : shift_q) << 1) | IO_WIDTH'(sdata_s2_q);
      in_word   = int'(cap_bit) < IO_WIDTH;
      wr_hit    = int'(cap_bit) == IO_WIDTH - 1;
      last_bit  = int'(cap_bit) == SLOT_WIDTH - 1;
      last_slot = int'(cap_slot) == NUM_CHANNELS - 1;
   end

   // frame FSM: bit/slot counting, sample writes, frame completion and error reporting
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         bank_q       <= 1'b0;
         bit_cnt_q    <= '0;
         slot_cnt_q   <= '0;
         shift_q      <= '0;
         done_pend_q  <= 1'b0;
         io_wr_en_q   <= 1'b0;
         io_wr_addr_q <= '0;
         io_wr_data_q <= '0;
         frame_done_q <= 1'b0;
         frame_bank_q <= 1'b0;
         frame_err_q  <= 1'b0;
         err_count_q  <= '0;
      end else begin
         io_wr_en_q   <= 1'b0;
         frame_done_q <= 1'b0;
         frame_err_q  <= 1'b0;

         // completion follows the last slot's write by one cycle; bank flips with it
         if (done_pend_q) begin
            done_pend_q  <= 1'b0;
            frame_done_q <= 1'b1;
            frame_bank_q <= bank_q;
            bank_q       <= ~bank_q;
         end

         if (capture) begin
            if (in_word) begin
               shift_q <= shift_d;
            end
            if (wr_hit) begin
               io_wr_en_q   <= 1'b1;
               io_wr_addr_q <= {bank_q, cap_slot};
               io_wr_data_q <= shift_d;
               done_pend_q  <= last_slot;
            end
            if (short_err) begin
               frame_err_q <= 1'b1;
               if (err_count_q != 8'hFF) begin
                  err_count_q <= err_count_q + 8'd1;
               end
            end
            if (last_bit) begin
               bit_cnt_q <= '0;
               if (last_slot) begin
                  slot_cnt_q <= '0;
                  state_q    <= WAIT_FS;
               end else begin
                  slot_cnt_q <= cap_slot + CH_ADDR_WIDTH'(1);
                  state_q    <= RUN;
               end
            end else begin
               bit_cnt_q  <= cap_bit + BIT_W'(1);
               slot_cnt_q <= cap_slot;
               state_q    <= RUN;
            end
         end
      end
   end

   assign io_wr_en   = io_wr_en_q;
   assign io_wr_addr = io_wr_addr_q;
   assign io_wr_data = io_wr_data_q;
   assign frame_done = frame_done_q;
   assign frame_bank = frame_bank_q;
   assign frame_err  = frame_err_q;
   assign err_count  = err_count_q;

endmodule

// File: tb/tb_tdm_rx_frame_buffer.sv
// Scoreboard testbench for tdm_rx_frame_buffer: expected writes and frame
// completions are queued as the TDM stream is generated and checked by a
// monitor as the DUT produces them.
module tb_tdm_rx_frame_buffer;

   localparam int IO_WIDTH     = 24;
   localparam int SLOT_WIDTH   = 32;
   localparam int NUM_CHANNELS = 8;
   localparam int CHW          = 3;

   logic              clk = 1'b0;
   logic              reset_n = 1'b0;
   logic              tdm_bclk = 1'b0;
   logic              tdm_fs = 1'b0;
   logic              tdm_sdata = 1'b0;
   logic              io_wr_en;
   logic [CHW:0]      io_wr_addr;
   logic [IO_WIDTH-1:0] io_wr_data;
   logic              frame_done;
   logic              frame_bank;
   logic              frame_err;
   logic [7:0]        err_count;

   typedef struct {
      logic [CHW:0]        addr;
      logic [IO_WIDTH-1:0] data;
   } wr_t;

   wr_t  wr_q[$];
   logic done_q[$];

   int   vectors = 0;
   int   miscompares = 0;
   int   err_seen = 0;
   logic tb_bank = 1'b0;
   logic last_done_bank = 1'b0;
   int   tb_err_cnt = 0;

   tdm_rx_frame_buffer #(
      .IO_WIDTH(IO_WIDTH), .SLOT_WIDTH(SLOT_WIDTH), .NUM_CHANNELS(NUM_CHANNELS), .CH_ADDR_WIDTH(CHW)
   ) dut (
      .clk(clk), .reset_n(reset_n), .tdm_bclk(tdm_bclk), .tdm_fs(tdm_fs), .tdm_sdata(tdm_sdata),
      .io_wr_en(io_wr_en), .io_wr_addr(io_wr_addr), .io_wr_data(io_wr_data),
      .frame_done(frame_done), .frame_bank(frame_bank), .frame_err(frame_err), .err_count(err_count)
   );

   always #5 clk = ~clk;

   // monitor: pop and compare every write and frame completion
   always @(negedge clk) begin
      if (reset_n) begin
         if (io_wr_en) begin
            vectors++;
            if (wr_q.size() == 0) begin
               miscompares++;
               $display("FAIL unexpected_write: got addr=%h data=%h, required no write", io_wr_addr, io_wr_data);
            end else begin
               wr_t e;
               e = wr_q.pop_front();
               if (io_wr_addr !== e.addr || io_wr_data !== e.data) begin
                  miscompares++;
                  $display("FAIL write: got addr=%h data=%h, required addr=%h data=%h",
                           io_wr_addr, io_wr_data, e.addr, e.data);
               end else begin
                  $display("write addr=%h data=%h ok", io_wr_addr, io_wr_data);
               end
            end
         end
         if (frame_done) begin
            vectors++;
            if (done_q.size() == 0) begin
               miscompares++;
               $display("FAIL unexpected_frame_done: got bank=%0d, required no frame_done", frame_bank);
            end else begin
               logic eb;
               eb = done_q.pop_front();
               if (frame_bank !== eb) begin
                  miscompares++;
                  $display("FAIL frame_bank: got %0d, required %0d", frame_bank, eb);
               end else begin
                  $display("frame_done bank=%0d ok", frame_bank);
               end
            end
         end
         if (frame_err) err_seen++;
      end
   end

   // watchdog so the run always ends
   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "timeout");
   end

   // one serial bit: 4 clk with bclk low, 4 clk high (clk = 8x bclk)
   task automatic send_bit(input logic fs, input logic d);
      tdm_fs    = fs;
      tdm_sdata = d;
      tdm_bclk  = 1'b0;
      repeat (4) @(negedge clk);
      tdm_bclk  = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task automatic send_word(input logic first_fs, input logic [SLOT_WIDTH-1:0] w);
      for (int i = 0; i < SLOT_WIDTH; i++)
         send_bit(first_fs && (i == 0), w[SLOT_WIDTH-1-i]);
   endtask

   function automatic logic [IO_WIDTH-1:0] slot_data(input int mode, input int n);
      if (mode == 1) return (n % 2 == 0) ? 24'h800001 : 24'h7FFFFF;
      return 24'h100000 + IO_WIDTH'(n);
   endfunction

   // full frame of nslots (extra slots beyond NUM_CHANNELS must be ignored)
   task automatic send_frame(input int mode, input int nslots);
      wr_t e;
      for (int n = 0; n < NUM_CHANNELS; n++) begin
         e.addr = {tb_bank, CHW'(n)};
         e.data = slot_data(mode, n);
         wr_q.push_back(e);
      end
      done_q.push_back(tb_bank);
      last_done_bank = tb_bank;
      tb_bank = ~tb_bank;
      for (int n = 0; n < nslots; n++) begin
         if (n < NUM_CHANNELS)
            send_word(n == 0, {slot_data(mode, n), (mode == 1) ? 8'h5A : 8'hFF});
         else
            send_word(1'b0, 32'hAAAA_AAAA);
      end
   endtask

   // nfull complete slots then nbits of the next slot; no completion
   task automatic send_partial(input int nfull, input int nbits);
      wr_t e;
      logic [SLOT_WIDTH-1:0] w;
      for (int n = 0; n < nfull; n++) begin
         e.addr = {tb_bank, CHW'(n)};
         e.data = slot_data(0, n);
         wr_q.push_back(e);
         send_word(n == 0, {slot_data(0, n), 8'hFF});
      end
      w = 32'hC3C3_C3C3;
      for (int i = 0; i < nbits; i++)
         send_bit((nfull == 0) && (i == 0), w[SLOT_WIDTH-1-i]);
   endtask

   task automatic settle();
      repeat (12) @(negedge clk);
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      vectors++;
      if ({io_wr_en, io_wr_addr, io_wr_data, frame_done, frame_bank, frame_err, err_count} !== '0) begin
         miscompares++;
         $display("FAIL reset_outputs: got en=%b addr=%h data=%h done=%b bank=%b err=%b cnt=%0d, required all 0",
                  io_wr_en, io_wr_addr, io_wr_data, frame_done, frame_bank, frame_err, err_count);
      end
      reset_n = 1'b1;
      repeat (3) @(negedge clk);
      $display("reset released");
   endtask

   task automatic test_normal_frames();
      int e0;
      e0 = err_seen;
      for (int f = 0; f < 3; f++) send_frame(0, NUM_CHANNELS);
      settle();
      vectors++;
      if (wr_q.size() != 0 || done_q.size() != 0) begin
         miscompares++;
         $display("FAIL normal_drain: got %0d writes %0d dones pending, required 0", wr_q.size(), done_q.size());
      end
      vectors++;
      if (err_seen != e0) begin
         miscompares++;
         $display("FAIL normal_err: got %0d err pulses, required 0", err_seen - e0);
      end
      vectors++;
      if (frame_bank !== last_done_bank) begin
         miscompares++;
         $display("FAIL normal_bank_hold: got %0d, required %0d", frame_bank, last_done_bank);
      end
   endtask

   task automatic test_signed();
      send_frame(1, NUM_CHANNELS);
      settle();
      vectors++;
      if (wr_q.size() != 0 || done_q.size() != 0) begin
         miscompares++;
         $display("FAIL signed_drain: got %0d writes %0d dones pending, required 0", wr_q.size(), done_q.size());
      end
   endtask

   task automatic test_short_frame();
      int e0;
      e0 = err_seen;
      send_partial(3, 5);
      send_frame(0, NUM_CHANNELS);
      tb_err_cnt++;
      settle();
      vectors++;
      if (err_seen - e0 != 1) begin
         miscompares++;
         $display("FAIL short_err_pulses: got %0d, required 1", err_seen - e0);
      end
      vectors++;
      if (int'(err_count) != tb_err_cnt) begin
         miscompares++;
         $display("FAIL short_err_count: got %0d, required %0d", err_count, tb_err_cnt);
      end
      vectors++;
      if (wr_q.size() != 0 || done_q.size() != 0) begin
         miscompares++;
         $display("FAIL short_drain: got %0d writes %0d dones pending, required 0", wr_q.size(), done_q.size());
      end
   endtask

   task automatic test_overlong();
      int e0;
      e0 = err_seen;
      send_frame(0, NUM_CHANNELS + 2);
      send_frame(0, NUM_CHANNELS);
      settle();
      vectors++;
      if (err_seen != e0) begin
         miscompares++;
         $display("FAIL overlong_err: got %0d err pulses, required 0", err_seen - e0);
      end
      vectors++;
      if (wr_q.size() != 0 || done_q.size() != 0) begin
         miscompares++;
         $display("FAIL overlong_drain: got %0d writes %0d dones pending, required 0", wr_q.size(), done_q.size());
      end
   endtask

   task automatic test_reset_mid_frame();
      send_partial(4, 10);
      #2 reset_n = 1'b0;
      #1;
      vectors++;
      if ({io_wr_en, io_wr_addr, io_wr_data, frame_done, frame_bank, frame_err, err_count} !== '0) begin
         miscompares++;
         $display("FAIL midreset_outputs: got en=%b addr=%h data=%h done=%b bank=%b err=%b cnt=%0d, required all 0",
                  io_wr_en, io_wr_addr, io_wr_data, frame_done, frame_bank, frame_err, err_count);
      end
      tb_bank = 1'b0;
      tb_err_cnt = 0;
      @(negedge clk);
      repeat (4) @(negedge clk);
      reset_n = 1'b1;
      for (int i = 0; i < 40; i++) send_bit(1'b0, i[0]);
      vectors++;
      if (wr_q.size() != 0 || done_q.size() != 0) begin
         miscompares++;
         $display("FAIL midreset_idle: got %0d writes %0d dones pending, required 0", wr_q.size(), done_q.size());
      end
      send_frame(0, NUM_CHANNELS);
      settle();
      vectors++;
      if (wr_q.size() != 0 || done_q.size() != 0) begin
         miscompares++;
         $display("FAIL midreset_frame: got %0d writes %0d dones pending, required 0", wr_q.size(), done_q.size());
      end
   endtask

   task automatic test_err_saturation();
      int e0;
      e0 = err_seen;
      for (int k = 0; k <= 300; k++) begin
         send_bit(1'b1, 1'b1);
         send_bit(1'b0, 1'b0);
         send_bit(1'b0, 1'b1);
         if (k > 0 && tb_err_cnt < 255) tb_err_cnt++;
      end
      settle();
      vectors++;
      if (err_seen - e0 != 300) begin
         miscompares++;
         $display("FAIL sat_err_pulses: got %0d, required 300", err_seen - e0);
      end
      vectors++;
      if (int'(err_count) != tb_err_cnt) begin
         miscompares++;
         $display("FAIL sat_err_count: got %0d, required %0d", err_count, tb_err_cnt);
      end
      vectors++;
      if (wr_q.size() != 0 || done_q.size() != 0) begin
         miscompares++;
         $display("FAIL sat_drain: got %0d writes %0d dones pending, required 0", wr_q.size(), done_q.size());
      end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_normal_frames();
      test_signed();
      test_short_frame();
      test_overlong();
      test_reset_mid_frame();
      test_err_saturation();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
